// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
// wb_select_stage : registered MEM/WB write-back source select with load
//                   lane extraction, write-enable qualification and flags
// Revision        : 1.0
// ============================================================================
module wb_select_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NSRC   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_we,
    input  logic [REG_AW-1:0]      in_rd,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [NSRC*DATA_W-1:0] in_src,
    input  logic [1:0]             in_ld_size,
    input  logic                   in_ld_uns,
    input  logic [1:0]             in_addr_lo,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   wb_valid,
    output logic                   wb_we,
    output logic [REG_AW-1:0]      wb_rd,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   wb_misalign,
    output logic                   wb_badsel
);

    logic [DATA_W-1:0] ld_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] sel_data;
    logic              sel_hit;
    logic              is_load;
    logic              misalign;
    logic              badsel;
    logic              next_we;

    logic              valid_d, valid_q;
    logic              we_d, we_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              mis_d, mis_q;
    logic              bad_d, bad_q;

    // Source 1 is the raw data-memory word; extract and extend the addressed lane.
    always_comb begin
        ld_word = in_src[DATA_W +: DATA_W];
        ld_byte = 8'h00;
        ld_half = 16'h0000;
        case (in_addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = in_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (in_ld_size)
            2'b00:   ld_data = {{24{~in_ld_uns & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~in_ld_uns & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_src[k*DATA_W +: DATA_W];
                sel_hit  = 1'b1;
            end
        end
        is_load  = (in_sel == SEL_W'(1));
        if (is_load) begin
            sel_data = ld_data;
        end
        misalign = in_valid & is_load &
                   (((in_ld_size == 2'b01) & in_addr_lo[0]) |
                    (in_ld_size[1] & (in_addr_lo != 2'b00)));
        badsel   = in_valid & ~sel_hit;
        next_we  = in_valid & in_we & (in_rd != '0) & ~misalign & ~badsel;
    end

    // Flush wins over stall; stall holds every output register.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        rd_d    = rd_q;
        data_d  = data_q;
        mis_d   = mis_q;
        bad_d   = bad_q;
        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            rd_d    = '0;
            data_d  = '0;
            mis_d   = 1'b0;
            bad_d   = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            we_d    = next_we;
            rd_d    = in_rd;
            data_d  = sel_data;
            mis_d   = misalign;
            bad_d   = badsel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
            bad_q   <= bad_d;
        end
    end

    assign wb_valid    = valid_q;
    assign wb_we       = we_q;
    assign wb_rd       = rd_q;
    assign wb_data     = data_q;
    assign wb_misalign = mis_q;
    assign wb_badsel   = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_select_stage.sv
`default_nettype none
// ============================================================================
// tb_wb_select_stage : directed self-checking bench for wb_select_stage
// Revision           : 1.0
// ============================================================================
module tb_wb_select_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_we, in_ld_uns, stall, flush;
    logic [4:0]   in_rd;
    logic [1:0]   in_sel, in_ld_size, in_addr_lo;
    logic [127:0] in_src;

    logic         wb_valid, wb_we, wb_misalign, wb_badsel;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;

    logic         b_valid, b_we, b_misalign, b_badsel;
    logic [4:0]   b_rd;
    logic [31:0]  b_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_select_stage #(.DATA_W(32), .REG_AW(5), .NSRC(4), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_we(in_we),
        .in_rd(in_rd), .in_sel(in_sel), .in_src(in_src),
        .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns), .in_addr_lo(in_addr_lo),
        .stall(stall), .flush(flush), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_misalign(wb_misalign),
        .wb_badsel(wb_badsel)
    );

    wb_select_stage #(.DATA_W(32), .REG_AW(5), .NSRC(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_we(in_we),
        .in_rd(in_rd), .in_sel(in_sel), .in_src(in_src[95:0]),
        .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns), .in_addr_lo(in_addr_lo),
        .stall(stall), .flush(flush), .wb_valid(b_valid), .wb_we(b_we),
        .wb_rd(b_rd), .wb_data(b_data), .wb_misalign(b_misalign),
        .wb_badsel(b_badsel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [31:0] v);
        in_src[k*32 +: 32] = v;
    endtask

    logic [31:0] fib [11] = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13,
                              32'd21, 32'd34, 32'd55, 32'd89, 32'd144};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_ld_uns = 1'b0;
        stall = 1'b0; flush = 1'b0; in_rd = '0; in_sel = '0;
        in_ld_size = '0; in_addr_lo = '0; in_src = '0;

        #12;
        check("rst_valid", 32'(wb_valid), 32'd0);
        check("rst_we",    32'(wb_we),    32'd0);
        check("rst_rd",    32'(wb_rd),    32'd0);
        check("rst_data",  wb_data,       32'd0);
        check("rst_mis",   32'(wb_misalign), 32'd0);
        check("rst_bad",   32'(wb_badsel),   32'd0);

        // ALU path
        rst_n = 1'b1;
        in_sel = 2'd0; set_src(0, 32'h0000_00FF); in_rd = 5'd3; in_we = 1'b1; in_valid = 1'b1;
        step();
        check("alu_data",  wb_data,        32'h0000_00FF);
        check("alu_we",    32'(wb_we),     32'd1);
        check("alu_rd",    32'(wb_rd),     32'd3);
        check("alu_valid", 32'(wb_valid),  32'd1);

        // Load extension
        in_sel = 2'd1; set_src(1, 32'h1234_8086);
        in_ld_size = 2'b00; in_addr_lo = 2'd0; in_ld_uns = 1'b0;
        step();
        check("lb_signed", wb_data, 32'hFFFF_FF86);
        check("lb_we",     32'(wb_we), 32'd1);
        in_ld_uns = 1'b1;
        step();
        check("lbu", wb_data, 32'h0000_0086);
        in_ld_uns = 1'b0; in_ld_size = 2'b01; in_addr_lo = 2'd2;
        step();
        check("lh_hi", wb_data, 32'h0000_1234);
        check("lh_hi_mis", 32'(wb_misalign), 32'd0);
        in_addr_lo = 2'd0;
        step();
        check("lh_lo", wb_data, 32'hFFFF_8086);
        in_ld_size = 2'b00; in_addr_lo = 2'd3; in_ld_uns = 1'b1;
        step();
        check("lbu_lane3", wb_data, 32'h0000_0012);

        // Fibonacci back-to-back word loads
        in_ld_size = 2'b10; in_addr_lo = 2'd0; in_ld_uns = 1'b0;
        for (int i = 0; i < 11; i++) begin
            set_src(1, fib[i]); in_rd = 5'(i + 1);
            step();
            check($sformatf("fib_data%0d", i), wb_data, fib[i]);
            check($sformatf("fib_we%0d", i),   32'(wb_we), 32'd1);
            check($sformatf("fib_rd%0d", i),   32'(wb_rd), 32'(i + 1));
        end

        // Misaligned half-word load
        set_src(1, 32'h1234_8086); in_ld_size = 2'b01; in_addr_lo = 2'd1; in_rd = 5'd4;
        step();
        check("mis_flag", 32'(wb_misalign), 32'd1);
        check("mis_we",   32'(wb_we),       32'd0);
        check("mis_data", wb_data,          32'hFFFF_8086);

        // Illegal select on a 3-source instance; legal on the 4-source one
        in_sel = 2'd3; set_src(3, 32'hDEAD_BEEF); in_ld_size = 2'b10; in_addr_lo = 2'd0;
        step();
        check("bad_flag",  32'(b_badsel), 32'd1);
        check("bad_data",  b_data,        32'd0);
        check("bad_we",    32'(b_we),     32'd0);
        check("sel3_data", wb_data,       32'hDEAD_BEEF);
        check("sel3_bad",  32'(wb_badsel), 32'd0);

        // Invalid instruction: flags and we gated
        in_valid = 1'b0;
        step();
        check("inv_bad", 32'(b_badsel), 32'd0);
        check("inv_we",  32'(wb_we),    32'd0);
        in_valid = 1'b1;

        // rd = 0 never written
        in_sel = 2'd0; in_rd = 5'd0; in_we = 1'b1;
        step();
        check("rd0_we",    32'(wb_we),    32'd0);
        check("rd0_valid", 32'(wb_valid), 32'd1);

        // Stall holds
        set_src(0, 32'h0000_00AA); in_rd = 5'd5;
        step();
        check("pre_stall", wb_data, 32'h0000_00AA);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_src(0, 32'h55 + 32'(i)); in_rd = 5'(9 + i);
            step();
            check($sformatf("stall_data%0d", i), wb_data, 32'h0000_00AA);
            check($sformatf("stall_rd%0d", i),   32'(wb_rd), 32'd5);
        end
        stall = 1'b0; set_src(0, 32'h0000_0055); in_rd = 5'd6;
        step();
        check("post_stall", wb_data, 32'h0000_0055);
        check("post_stall_rd", 32'(wb_rd), 32'd6);

        // Flush overrides stall
        stall = 1'b1; flush = 1'b1;
        step();
        check("flush_valid", 32'(wb_valid), 32'd0);
        check("flush_we",    32'(wb_we),    32'd0);
        check("flush_data",  wb_data,       32'd0);
        check("flush_rd",    32'(wb_rd),    32'd0);
        stall = 1'b0; flush = 1'b0;

        // Asynchronous reset between edges
        set_src(0, 32'h0000_0077); in_rd = 5'd7;
        step();
        check("pre_arst_we", 32'(wb_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we",    32'(wb_we),    32'd0);
        check("arst_data",  wb_data,       32'd0);
        check("arst_valid", 32'(wb_valid), 32'd0);
        check("arst_rd",    32'(wb_rd),    32'd0);
        #3 rst_n = 1'b1;
        step();
        check("post_arst_data", wb_data, 32'h0000_0077);
        check("post_arst_we",   32'(wb_we), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_select_stage.md
# wb_select_stage

Registered write-back selection stage for the MIPS pipeline: the parametrised successor to the two-input memtoReg mux. It captures the MEM-stage result sources in a MEM/WB pipeline register and selects one of NSRC sources. Loads get byte/half/word extraction with sign or zero extension. The stage supports stall, flush, write-enable qualification and exception flags. Its outputs drive the register-file write port and the forwarding unit.

## Interface
- DATA_W, 32, datapath width; must be 32 (lane logic is fixed at 4 bytes)
- REG_AW, 5, register-file address width
- NSRC, 4, number of write-back sources; source 0 = ALU result, source 1 = data-memory word, 2..NSRC-1 generic (e.g. PC+8 link, LUI immediate)
- SEL_W, 2, select width; 2^SEL_W >= NSRC
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  MEM-stage instruction valid
- in_we  input  1  instruction writes a register
- in_rd  input  REG_AW  destination register
- in_sel  input  SEL_W  source select
- in_src  input  NSRC*DATA_W  packed sources; source k at bits [k*DATA_W +: DATA_W]
- in_ld_size  input  2  00 byte, 01 half, 10/11 word
- in_ld_uns  input  1  1 = zero-extend, 0 = sign-extend
- in_addr_lo  input  2  byte offset of the load address (ALU result [1:0])
- stall  input  1  hold the stage register
- flush  input  1  squash: load a bubble
- wb_valid  output  1  registered valid
- wb_we  output  1  qualified register-file write enable
- wb_rd  output  REG_AW  registered destination
- wb_data  output  DATA_W  registered write-back data
- wb_misalign  output  1  registered misaligned-load flag
- wb_badsel  output  1  registered illegal-select flag

## Operation
- Combinational next value from inputs, captured on the clock edge.
- Data selection:
  - Source 1 (in_sel==1) is load-processed:
    - byte: lane = in_addr_lo, bits [8*lane +: 8], extended to 32.
    - half: lane = in_addr_lo[1], bits [16*lane +: 16], extended.
    - word: passed unchanged.
  - All other sources are passed unchanged; in_ld_size and in_ld_uns are ignored.
- Misalignment, flagged only when in_sel==1 and in_valid:
  - half with in_addr_lo[0]=1, or word with in_addr_lo!=0.
  - Data is still the extracted value (half uses lane in_addr_lo[1]); word passes unchanged.
- in_sel >= NSRC: badsel=1 and data=0.
- Write-enable qualification: next we = in_valid & in_we & (in_rd!=0) & ~misalign & ~badsel. Register 0 is never written.
- Flags are valid-gated: with in_valid=0 both flags are 0 and we is 0. wb_data and wb_rd still capture their computed values.
- Update priority per edge:
  - flush: wb_valid, wb_we, wb_misalign, wb_badsel cleared; wb_rd and wb_data cleared to 0.
  - else stall: all outputs hold.
  - else load the next values.
- flush overrides stall when both are asserted.

## Timing
- Latency: one cycle from inputs to wb_* outputs; there is no combinational path from inputs to outputs.
- Reset (rst_n low, any time, asynchronous): all outputs 0. Reset mid-stall or mid-flush discards the held state.
- First edge after rst_n rises loads normally.
- Stall of N cycles holds the outputs N extra cycles; the instruction presented on the first unstalled edge is captured.
- Back-to-back valid instructions produce one result per cycle.

## Test plan
- Reset and ALU path: rst_n=0 gives all outputs 0. Release, then sel=0, src0=0x000000FF, rd=3, we=1, valid=1. Next edge: wb_data=0x000000FF, wb_we=1, wb_rd=3.
- Load extension, src1=0x1234_8086:
  - byte, addr_lo=0, signed: 0xFFFFFF86.
  - same, unsigned: 0x00000086.
  - half, addr_lo=2, signed: 0x00001234.
  - half, addr_lo=0, signed: 0xFFFF8086.
- Fibonacci write sequence: sel=1, word loads 1,2,3,5,8,13,21,34,55,89,144 into rd=1..11 on consecutive cycles. Each value appears one cycle later with wb_we=1 and the matching wb_rd.
- Hazards, each case separately:
  - half, addr_lo=1: wb_misalign=1, wb_we=0.
  - sel=3 with NSRC=3: wb_badsel=1, wb_data=0, wb_we=0.
  - rd=0 with we=1: wb_we=0.
- Stall and flush:
  - Load 0xAA, then stall 3 cycles while inputs change: wb_data stays 0xAA.
  - stall=1 with flush=1: next edge gives wb_valid=0, wb_we=0, wb_data=0.
- Asynchronous reset: drop rst_n mid-cycle between edges while wb_we=1. Outputs go to 0 immediately, without waiting for a clock edge.
